// File: rtl/psk_symbol_mapper.sv
// psk_symbol_mapper
//
// Unpacks IN_WIDTH-bit AXI-stream data words into one complex I/Q sample per
// symbol, MSB first. It supports BPSK (one bit per symbol) or QPSK (two bits
// per symbol), selectable per word, at a configurable amplitude. The packet
// tlast is carried onto the final symbol of a word. It honours full
// backpressure and streams back-to-back words with no idle cycles.
//
// Parameters:
//   IN_WIDTH    input word width, even, 2..64
//   AMP         positive symbol level (two's complement); bit 1 maps to -AMP
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   mode        0 = BPSK, 1 = QPSK; sampled when a word is accepted
//   in_tdata    packed input bits, MSB transmitted first
//   in_tlast    last word of the packet
//   in_tvalid   input valid
//   in_tready   input ready (never depends combinationally on in_tvalid)
//   out_tdata   sample {[31:16], [15:0]}; BPSK puts zero in [15:0]
//   out_tlast   last symbol of the packet
//   out_tvalid  output valid
//   out_tready  downstream ready
//   busy        a word is held or a symbol is still waiting at the output

module psk_symbol_mapper #(
    parameter int          IN_WIDTH = 32,
    parameter logic [15:0] AMP      = 16'h6665
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic [IN_WIDTH-1:0] in_tdata,
    input  logic                in_tlast,
    input  logic                in_tvalid,
    output logic                in_tready,
    output logic [31:0]         out_tdata,
    output logic                out_tlast,
    output logic                out_tvalid,
    input  logic                out_tready,
    output logic                busy
);

    localparam int          KW        = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;
    localparam logic [15:0] NEG       = ~AMP + 16'd1;
    localparam logic [KW-1:0] LAST_BPSK = KW'(IN_WIDTH - 1);
    localparam logic [KW-1:0] LAST_QPSK = KW'(IN_WIDTH / 2 - 1);

    typedef enum logic {
        EMPTY,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   word_q, word_d;
    logic                  mode_q, mode_d;
    logic                  last_q, last_d;
    logic [KW-1:0]         k_q, k_d;
    logic [31:0]           outData_q, outData_d;
    logic                  outLast_q, outLast_d;
    logic                  outValid_q, outValid_d;

    logic                  adv;
    logic                  lastSym;
    logic                  accept;
    logic [KW-1:0]         lastIdx;
    logic [KW-1:0]         hiIdx;
    logic [KW-1:0]         loIdx;
    logic [15:0]           hiLevel;
    logic [15:0]           loLevel;
    logic [31:0]           symData;

    // The output register may take a new symbol whenever it is empty or
    // its current symbol is being consumed this cycle.
    assign adv     = !outValid_q || out_tready;
    assign lastIdx = mode_q ? LAST_QPSK : LAST_BPSK;
    assign lastSym = (k_q == lastIdx);

    // A new word is taken only when nothing is held, or when the held word's
    // final symbol is moving into the output register this very cycle. That
    // keeps words flowing back-to-back without a gap.
    assign in_tready = !reset && ((state_q == EMPTY) ||
                                  ((state_q == HOLD) && lastSym && adv));
    assign accept    = in_tvalid && in_tready;

    // Symbol k starts at bit IN_WIDTH-1-k (BPSK) or IN_WIDTH-1-2k (QPSK).
    // The QPSK second bit sits just below it.
    assign hiIdx   = mode_q ? (LAST_BPSK - (k_q << 1)) : (LAST_BPSK - k_q);
    assign loIdx   = hiIdx - KW'(1);
    assign hiLevel = word_q[hiIdx] ? NEG : AMP;
    assign loLevel = word_q[loIdx] ? NEG : AMP;
    assign symData = mode_q ? {loLevel, hiLevel} : {hiLevel, 16'h0000};

    // Next-state logic: load the next symbol when the output can advance,
    // then latch a newly accepted word. The accept overrides the drop to
    // EMPTY that the final symbol would otherwise cause.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        mode_d     = mode_q;
        last_d     = last_q;
        k_d        = k_q;
        outData_d  = outData_q;
        outLast_d  = outLast_q;
        outValid_d = outValid_q;

        if (adv) begin
            if (state_q == HOLD) begin
                outData_d  = symData;
                outLast_d  = last_q && lastSym;
                outValid_d = 1'b1;
                k_d        = k_q + KW'(1);
                if (lastSym) begin
                    state_d = EMPTY;
                end
            end else begin
                outValid_d = 1'b0;
            end
        end

        if (accept) begin
            word_d  = in_tdata;
            mode_d  = mode;
            last_d  = in_tlast;
            k_d     = '0;
            state_d = HOLD;
        end
    end

    // State and output registers. Reset discards any held word and any
    // pending sample at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            word_q     <= '0;
            mode_q     <= 1'b0;
            last_q     <= 1'b0;
            k_q        <= '0;
            outData_q  <= 32'h0;
            outLast_q  <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            mode_q     <= mode_d;
            last_q     <= last_d;
            k_q        <= k_d;
            outData_q  <= outData_d;
            outLast_q  <= outLast_d;
            outValid_q <= outValid_d;
        end
    end

    assign out_tdata  = outData_q;
    assign out_tlast  = outLast_q;
    assign out_tvalid = outValid_q;
    assign busy       = (state_q == HOLD) || outValid_q;

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Testbench for psk_symbol_mapper: a 32-bit instance at the default amplitude
// with directed vectors, and an 8-bit instance at amplitude 16'h4000 driven
// with random backpressure against a bit-level reference model.

module tb_psk_symbol_mapper;

    logic        clk = 1'b0;
    logic        reset;

    logic        mode;
    logic [31:0] inData;
    logic        inLast;
    logic        inValid;
    logic        inReady;
    logic [31:0] outData;
    logic        outLast;
    logic        outValid;
    logic        outReady;
    logic        busy;

    logic        mode8;
    logic [7:0]  inData8;
    logic        inLast8;
    logic        inValid8;
    logic        inReady8;
    logic [31:0] outData8;
    logic        outLast8;
    logic        outValid8;
    logic        outReady8;
    logic        busy8;

    always #5 clk = ~clk;

    psk_symbol_mapper #(.IN_WIDTH(32), .AMP(16'h6665)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .in_tdata(inData), .in_tlast(inLast), .in_tvalid(inValid), .in_tready(inReady),
        .out_tdata(outData), .out_tlast(outLast), .out_tvalid(outValid), .out_tready(outReady),
        .busy(busy)
    );

    psk_symbol_mapper #(.IN_WIDTH(8), .AMP(16'h4000)) dut8 (
        .clk(clk), .reset(reset), .mode(mode8),
        .in_tdata(inData8), .in_tlast(inLast8), .in_tvalid(inValid8), .in_tready(inReady8),
        .out_tdata(outData8), .out_tlast(outLast8), .out_tvalid(outValid8), .out_tready(outReady8),
        .busy(busy8)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        m;
        logic [31:0] word;
        logic        tl;
        int          nSym;
        logic [31:0] sym0;
        logic [31:0] sym1;
        logic [31:0] symRest;
        logic [31:0] symLast;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] gotData[64];
    logic        gotLast[64];
    int          gotCount;

    logic [31:0] words3[3];
    logic        last3[3];
    logic        rdyLog[56];
    logic        valLog[56];
    logic [31:0] datLog[56];
    logic        lastLog[56];
    int          widx;
    logic        acc;
    int          seen;

    logic [7:0]  words8[16];
    logic        modes8[16];
    logic [31:0] expData8[$];
    logic        expLast8[$];
    int          total8;
    int          received8;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] refSymbol(input int width, input logic m, input logic [63:0] w,
                                               input int k, input logic [15:0] amp);
        logic [15:0] neg;
        logic        bHi;
        logic        bLo;
        neg = 16'd0 - amp;
        if (m) begin
            bHi = w[width - 1 - 2 * k];
            bLo = w[width - 2 - 2 * k];
            return {(bLo ? neg : amp), (bHi ? neg : amp)};
        end
        bHi = w[width - 1 - k];
        return {(bHi ? neg : amp), 16'h0000};
    endfunction

    // Offer one word to the 32-bit instance, then confirm symbol 0 appears
    // exactly one cycle after acceptance. The mode input is flipped right
    // after acceptance, which must not affect the held word.
    task automatic applyStimulus(input logic m, input logic [31:0] w, input logic tl);
        for (int c = 0; c < 50 && !inReady; c++) begin
            @(posedge clk); #1;
        end
        if (!inReady) begin
            checkOutput("accept_timeout", 0, 1);
            return;
        end
        mode    = m;
        inData  = w;
        inLast  = tl;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        mode    = ~m;
        checkOutput("latency_gap", outValid, 0);
        @(posedge clk); #1;
        checkOutput("latency_valid", outValid, 1);
    endtask

    task automatic collect(input int n);
        gotCount = 0;
        for (int c = 0; c < n + 40 && gotCount < n; c++) begin
            if (outValid && outReady) begin
                gotData[gotCount] = outData;
                gotLast[gotCount] = outLast;
                gotCount++;
            end
            @(posedge clk); #1;
        end
        checkOutput("symbol_count", gotCount, n);
    endtask

    task automatic runVector(input int i);
        logic [31:0] exp;
        outReady = 1'b1;
        applyStimulus(vecs[i].m, vecs[i].word, vecs[i].tl);
        collect(vecs[i].nSym);
        for (int k = 0; k < gotCount; k++) begin
            if (k == 0)                   exp = vecs[i].sym0;
            else if (k == 1)              exp = vecs[i].sym1;
            else if (k == vecs[i].nSym-1) exp = vecs[i].symLast;
            else                          exp = vecs[i].symRest;
            checkOutput($sformatf("vec%0d_sym%0d_data", i, k), gotData[k], exp);
            checkOutput($sformatf("vec%0d_sym%0d_last", i, k), gotLast[k],
                        vecs[i].tl && (k == vecs[i].nSym - 1));
        end
        checkOutput($sformatf("vec%0d_drain_valid", i), outValid, 0);
        checkOutput($sformatf("vec%0d_drain_busy", i), busy, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h00000001, 1'b0, 16, 32'h66656665, 32'h66656665, 32'h66656665, 32'h999B6665};
        vecs[1] = '{1'b1, 32'hC0000002, 1'b1, 16, 32'h999B999B, 32'h66656665, 32'h66656665, 32'h6665999B};
        vecs[2] = '{1'b0, 32'h80000000, 1'b0, 32, 32'h999B0000, 32'h66650000, 32'h66650000, 32'h66650000};
        vecs[3] = '{1'b0, 32'h00000001, 1'b1, 32, 32'h66650000, 32'h66650000, 32'h66650000, 32'h999B0000};
        vecs[4] = '{1'b1, 32'h60000000, 1'b0, 16, 32'h999B6665, 32'h6665999B, 32'h66656665, 32'h66656665};

        reset     = 1'b1;
        mode      = 1'b1;
        inData    = 32'h0;
        inLast    = 1'b0;
        inValid   = 1'b0;
        outReady  = 1'b1;
        mode8     = 1'b0;
        inData8   = 8'h0;
        inLast8   = 1'b0;
        inValid8  = 1'b0;
        outReady8 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_tready", inReady, 0);
        checkOutput("reset_out_tvalid", outValid, 0);
        checkOutput("reset_out_tdata", outData, 32'h0);
        checkOutput("reset_out_tlast", outLast, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b0;
        #1;
        checkOutput("release_in_tready", inReady, 1);
        @(posedge clk); #1;

        // Table-driven single words
        for (int i = 0; i < 5; i++) begin
            runVector(i);
        end

        // Stalls: output holds still, and the next word is refused while the
        // final symbol cannot move.
        applyStimulus(1'b1, 32'h60000001, 1'b0);
        outReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput("stall_hold_data", outData, 32'h999B6665);
            checkOutput("stall_hold_valid", outValid, 1);
            checkOutput("stall_ready_low", inReady, 0);
        end
        outReady = 1'b1;
        seen = 0;
        for (int c = 0; c < 40 && seen < 15; c++) begin
            if (outValid) seen++;
            if (seen < 15) begin
                @(posedge clk); #1;
            end
        end
        checkOutput("stall_walk_seen", seen, 15);
        outReady = 1'b0;
        #1;
        checkOutput("stall_last_ready_low", inReady, 0);
        checkOutput("stall_sym14", outData, 32'h66656665);
        @(posedge clk); #1;
        checkOutput("stall_sym14_hold", outData, 32'h66656665);
        checkOutput("stall_sym14_valid", outValid, 1);
        outReady = 1'b1;
        #1;
        checkOutput("stall_last_ready_high", inReady, 1);
        @(posedge clk); #1;
        checkOutput("stall_sym15", outData, 32'h999B6665);
        @(posedge clk); #1;
        checkOutput("stall_end_valid", outValid, 0);
        checkOutput("stall_end_busy", busy, 0);

        // Reset while symbol 7 of a QPSK word is on the output
        applyStimulus(1'b1, 32'h00000001, 1'b0);
        seen = 0;
        for (int c = 0; c < 40 && seen < 8; c++) begin
            if (outValid) seen++;
            if (seen < 8) begin
                @(posedge clk); #1;
            end
        end
        checkOutput("midreset_seen", seen, 8);
        reset = 1'b1;
        #1;
        checkOutput("midreset_valid", outValid, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_ready", inReady, 0);
        checkOutput("midreset_data", outData, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("midreset_release_ready", inReady, 1);
        @(posedge clk); #1;
        runVector(1);

        // Three back-to-back QPSK words with in_tvalid held high
        words3 = '{32'h00000001, 32'hC0000002, 32'h60000000};
        last3  = '{1'b0, 1'b1, 1'b0};
        outReady = 1'b1;
        mode     = 1'b1;
        widx     = 0;
        inData   = words3[0];
        inLast   = last3[0];
        inValid  = 1'b1;
        for (int c = 0; c < 56; c++) begin
            rdyLog[c]  = inReady;
            valLog[c]  = outValid;
            datLog[c]  = outData;
            lastLog[c] = outLast;
            acc = inValid && inReady;
            @(posedge clk); #1;
            if (acc) begin
                widx++;
                if (widx < 3) begin
                    inData = words3[widx];
                    inLast = last3[widx];
                end else begin
                    inValid = 1'b0;
                end
            end
        end
        inValid = 1'b0;
        checkOutput("b2b_words_accepted", widx, 3);
        for (int c = 1; c < 56; c++) begin
            checkOutput($sformatf("b2b_valid_c%0d", c), valLog[c], (c >= 2) && (c <= 49));
            if (c <= 48)
                checkOutput($sformatf("b2b_ready_c%0d", c), rdyLog[c], (c == 16) || (c == 32) || (c == 48));
            if (c >= 2 && c <= 49) begin
                checkOutput($sformatf("b2b_data_c%0d", c), datLog[c],
                            refSymbol(32, 1'b1, {32'h0, words3[(c - 2) / 16]}, (c - 2) % 16, 16'h6665));
                checkOutput($sformatf("b2b_last_c%0d", c), lastLog[c], c == 33);
            end
        end

        // 8-bit instance, random words and modes, random out_tready
        for (int i = 0; i < 16; i++) begin
            words8[i] = 8'($urandom_range(0, 255));
            modes8[i] = 1'($urandom_range(0, 1));
            for (int k = 0; k < (modes8[i] ? 4 : 8); k++) begin
                expData8.push_back(refSymbol(8, modes8[i], {56'h0, words8[i]}, k, 16'h4000));
                expLast8.push_back(k == (modes8[i] ? 3 : 7));
            end
        end
        total8 = expData8.size();
        received8 = 0;
        @(posedge clk); #1;
        fork
            begin : driver8
                logic got;
                #1;
                for (int i = 0; i < 16; i++) begin
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                        mode8 = 1'($urandom_range(0, 1));
                        @(posedge clk); #2;
                    end
                    mode8    = modes8[i];
                    inData8  = words8[i];
                    inLast8  = 1'b1;
                    inValid8 = 1'b1;
                    got = 1'b0;
                    for (int c = 0; c < 200 && !got; c++) begin
                        got = inReady8;
                        @(posedge clk); #2;
                    end
                    inValid8 = 1'b0;
                    mode8    = ~modes8[i];
                    if (!got) checkOutput($sformatf("rand_accept_timeout_w%0d", i), 0, 1);
                end
            end
            begin : monitor8
                logic        stalled;
                logic [31:0] heldData;
                logic        heldLast;
                stalled = 1'b0;
                heldData = 32'h0;
                heldLast = 1'b0;
                for (int c = 0; c < 3000 && received8 < total8; c++) begin
                    if (stalled)
                        checkOutput("rand_stall_stable", {outValid8, outLast8, outData8},
                                    {1'b1, heldLast, heldData});
                    outReady8 = 1'($urandom_range(0, 1));
                    if (outValid8 && outReady8) begin
                        checkOutput($sformatf("rand_sym%0d_data", received8), outData8, expData8[received8]);
                        checkOutput($sformatf("rand_sym%0d_last", received8), outLast8, expLast8[received8]);
                        received8++;
                        stalled = 1'b0;
                    end else if (outValid8) begin
                        stalled  = 1'b1;
                        heldData = outData8;
                        heldLast = outLast8;
                    end else begin
                        stalled = 1'b0;
                    end
                    @(posedge clk); #1;
                end
            end
        join
        checkOutput("rand_symbol_total", received8, total8);
        outReady8 = 1'b1;
        @(posedge clk); #1;
        checkOutput("rand_no_extra_valid", outValid8, 0);
        checkOutput("rand_idle_busy", busy8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psk_symbol_mapper.md
# psk_symbol_mapper

Parametrised AXI-stream bit-to-symbol mapper that unpacks IN_WIDTH-bit data words into one complex I/Q sample per symbol. It supports run-time BPSK or QPSK selection and a configurable amplitude, and propagates tlast. It sits between the RFNoC input port and the pulse-shaping/DAC path, upstream of the interpolating filter. Full AXI-stream backpressure is honoured and back-to-back words stream with no bubbles.

## Interface
- IN_WIDTH, 32, input word width; even, 2..64.
- AMP, 16'h6665, positive symbol level, two's complement; 80% of DAC full scale. Negative level NEG = -AMP (16'h999B at default).
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  reset, asynchronous, active-high.
- mode  in  1  0 = BPSK, 1 = QPSK; sampled only when an input word is accepted.
- in_tdata  in  IN_WIDTH  packed bits, MSB transmitted first.
- in_tlast  in  1  last word of packet.
- in_tvalid  in  1  input valid.
- in_tready  out  1  input ready.
- out_tdata  out  32  sample {[31:16], [15:0]}.
- out_tlast  out  1  last symbol of a packet.
- out_tvalid  out  1  output valid.
- out_tready  in  1  downstream ready.
- busy  out  1  a word is held or a symbol is pending output.

## Operation
- Bit map: bit 0 -> AMP, bit 1 -> NEG.
- Symbols per word: N = IN_WIDTH/2 in QPSK, N = IN_WIDTH in BPSK. The symbol index k runs 0..N-1.
- QPSK symbol k: b_hi = word[IN_WIDTH-1-2k], b_lo = word[IN_WIDTH-2-2k]. out_tdata = {map(b_lo), map(b_hi)}.
  - Pairs 00 -> {AMP,AMP}, 01 -> {NEG,AMP}, 10 -> {AMP,NEG}, 11 -> {NEG,NEG}.
- BPSK symbol k: b = word[IN_WIDTH-1-k]. out_tdata = {map(b), 16'h0000}.
- Storage:
  - One holding register: word, mode, tlast, valid flag.
  - Symbol index counter, width clog2(IN_WIDTH).
  - Registered output stage: out_tdata, out_tlast, out_tvalid.
- States:
  - EMPTY: no word held. in_tready = 1.
  - HOLD: word held and symbols remain to be emitted.
- Accept: a word is accepted when in_tvalid && in_tready. On acceptance, word, mode and tlast are latched, k is set to 0, and the state goes to HOLD.
- Output advance: adv = !out_tvalid || out_tready.
  - In HOLD with adv, the output register loads symbol k and k increments.
  - out_tlast = held tlast && (k == N-1).
- When k == N-1 is loaded:
  - If the input is accepted in the same cycle, the new word is latched, k = 0 and the state stays HOLD.
  - Otherwise the state goes to EMPTY.
- in_tready is combinational: !reset && (EMPTY || (HOLD && k == N-1 && adv)). There is no combinational path from in_tvalid to in_tready.
- When HOLD has nothing left to load and no new word arrives, out_tvalid clears on the next out_tready.
- out_tdata and out_tlast hold stable while out_tvalid && !out_tready.
- A mode change while a word is held is ignored until the next acceptance.
- busy = HOLD || out_tvalid.

## Timing
- Reset values:
  - out_tvalid = 0, out_tdata = 32'h0, out_tlast = 0, busy = 0.
  - in_tready = 0 while reset is high, and 1 in the first cycle after release.
  - The state returns to EMPTY and k = 0.
- Reset asserted mid-word: the held word and any pending output are discarded immediately, with no partial flush.
- Latency: word accepted at edge t -> symbol 0 valid after edge t+1.
- Throughput: with out_tready held high, one symbol per clock and a continuous stream across word boundaries. A new word is accepted in the same cycle its predecessor's last symbol loads.
- Under a stall (out_tready low), no symbol is dropped or duplicated. in_tready stays low until the last symbol can advance.

## Test plan
- Reset, then QPSK word 32'h00000001 with out_tready = 1:
  - 16 consecutive symbols.
  - Symbols 0..14 = 32'h66656665, symbol 15 = 32'h999B6665.
  - Symbol 0 valid one cycle after acceptance.
- QPSK word 32'hC0000002 with tlast = 1:
  - Symbol 0 = 32'h999B999B, symbol 15 = 32'h6665999B.
  - out_tlast high only on symbol 15.
- BPSK (mode = 0), word 32'h80000000:
  - 32 symbols.
  - Symbol 0 = 32'h999B0000, the rest = 32'h66650000.
- Three back-to-back QPSK words with in_tvalid held high and out_tready = 1:
  - 48 contiguous valid cycles with no gaps.
  - in_tready pulses exactly on the cycles symbol 15 loads.
- Random out_tready toggling, IN_WIDTH = 8, AMP = 16'h4000:
  - The output sequence matches the reference model with no loss or duplication.
  - out_tdata is stable during stalls.
  - Each word yields 4 QPSK or 8 BPSK symbols.
- Assert reset at symbol 7 of a QPSK word:
  - out_tvalid drops immediately and busy = 0.
  - After release, the next word starts at symbol 0 with correct data.
